// File: rtl/alu_op_issue.sv
// alu_op_issue: RV32 R/I-type decode and issue stage driving the ALU operand bundle.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        instr + rs1_val + rs2_val handshake
//   out_valid/out_ready      registered op1/op2/opcode/funct3/funct7/rd handshake
//   illegal                  1-cycle pulse when an accepted instruction is dropped
//   perf_issued/perf_stall   issue/stall counters, only with ALU_ISSUE_PERF_EN defined
module alu_op_issue #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [WIDTH-1:0]   rs1_val,
    input  logic [WIDTH-1:0]   rs2_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   op1,
    output logic [WIDTH-1:0]   op2,
    output logic [6:0]         opcode,
    output logic [2:0]         funct3,
    output logic [6:0]         funct7,
    output logic [REGADDR-1:0] rd,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall,
`endif
    output logic               illegal
);
    localparam int SH = $clog2(WIDTH);
    localparam int BW = 2 * WIDTH + 17 + REGADDR;

    logic is_r, is_i, is_sh, f7_base, bad, accept, fwd, out_v, skid_v;
    logic [WIDTH-1:0] dec_op2;
    logic [6:0] dec_f7;
    logic [BW-1:0] new_b, out_b, skid_b;
    logic unused_rs1_idx;

    // rs1 index is resolved by the register file upstream; only its data arrives here.
    assign unused_rs1_idx = ^instr[19:15];
    assign is_r    = instr[6:0] == 7'b0110011;
    assign is_i    = instr[6:0] == 7'b0010011;
    // funct3 001 and 101 share bits [13:12] = 01
    assign is_sh   = is_i && instr[13:12] == 2'b01;
    assign f7_base = instr[31:25] == 7'h00 || instr[31:25] == 7'h20;
    assign bad     = !(is_r || is_i) || (is_r && !(f7_base || instr[31:25] == 7'h01)) || (is_sh && !f7_base);
    assign dec_op2 = is_r ? rs2_val : is_sh ? {{(WIDTH-SH){1'b0}}, instr[20 +: SH]} : {{(WIDTH-12){instr[31]}}, instr[31:20]};
    assign dec_f7  = (is_r || is_sh) ? instr[31:25] : 7'd0;
    assign new_b   = {rs1_val, dec_op2, instr[6:0], instr[14:12], dec_f7, instr[7 +: REGADDR]};

    assign in_ready  = !skid_v;
    assign out_valid = out_v;
    assign accept    = in_valid && in_ready;
    assign fwd       = accept && !bad;
    assign {op1, op2, opcode, funct3, funct7, rd} = out_b;

    // SKID only fills while OUT is stalled; it always drains into OUT first,
    // so order is preserved and in_ready depends on a flop only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v   <= 1'b0;
            skid_v  <= 1'b0;
            out_b   <= '0;
            skid_b  <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= accept && bad;
            if (!out_v || out_ready) begin
                if (skid_v) begin
                    out_b  <= skid_b;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                end else if (fwd) begin
                    out_b <= new_b;
                    out_v <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (fwd) begin
                skid_b <= new_b;
                skid_v <= 1'b1;
            end
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            perf_issued <= perf_issued + {31'd0, out_v && out_ready};
            perf_stall  <= perf_stall + {31'd0, out_v && !out_ready};
        end
    end
`endif
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: scoreboard bench for alu_op_issue (default build, perf counters absent).
module tb_alu_op_issue;
    logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
    logic [31:0] instr = 0, rs1_val = 0, rs2_val = 0;
    logic in_ready, out_valid, illegal;
    logic [31:0] op1, op2;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd;

    int checks = 0, errors = 0, fired = 0;
    logic [85:0] q[$];
    logic [85:0] mon_e, mon_a;
    logic mon_ok;

    alu_op_issue #(.WIDTH(32), .REGADDR(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic model(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2, output logic [85:0] b);
        logic [6:0] f7;
        f7 = i[31:25];
        b = '0;
        if (i[6:0] == 7'h33) begin
            b = {r1, r2, i[6:0], i[14:12], f7, i[11:7]};
            return f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01;
        end
        if (i[6:0] == 7'h13) begin
            if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
                b = {r1, 27'd0, i[24:20], i[6:0], i[14:12], f7, i[11:7]};
                return f7 == 7'h00 || f7 == 7'h20;
            end
            b = {r1, {20{i[31]}}, i[31:20], i[6:0], i[14:12], 7'd0, i[11:7]};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Inputs change just after posedge, so the negedge sees the values the next edge will use.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            fired++;
            mon_a = {op1, op2, opcode, funct3, funct7, rd};
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got=%h expected=none", mon_a);
            end else begin
                mon_e = q.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL sb_bundle got=%h expected=%h", mon_a, mon_e);
                end
            end
        end
        mon_ok = model(instr, rs1_val, rs2_val, mon_e);
        if (rst_n && in_valid && in_ready && mon_ok) q.push_back(mon_e);
    end

    task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        int n = 0;
        logic acc = 0;
        instr = i; rs1_val = r1; rs2_val = r2; in_valid = 1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 0;
        if (!acc) begin errors++; $display("FAIL send_timeout instr=%h never accepted", i); end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL drain got=%0d pending expected=0", q.size()); end
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%b expected=0", illegal); end
        checks++; if ({op1, op2, opcode, funct3, funct7, rd} !== 86'd0) begin errors++; $display("FAIL rst_bundle got=%h expected=0", {op1, op2, opcode, funct3, funct7, rd}); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        out_ready = 1;
        send(32'h002081B3, 32'd5, 32'd7);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b expected=1", out_valid); end
        checks++; if (op1 !== 32'd5) begin errors++; $display("FAIL add_op1 got=%h expected=5", op1); end
        checks++; if (op2 !== 32'd7) begin errors++; $display("FAIL add_op2 got=%h expected=7", op2); end
        checks++; if (opcode !== 7'h33) begin errors++; $display("FAIL add_opcode got=%h expected=33", opcode); end
        checks++; if (funct3 !== 3'd0 || funct7 !== 7'd0) begin errors++; $display("FAIL add_funct got=%h/%h expected=0/0", funct3, funct7); end
        checks++; if (rd !== 5'd3) begin errors++; $display("FAIL add_rd got=%0d expected=3", rd); end
        drain();
    endtask

    task automatic test_itype();
        send(32'hFFF00093, 32'd0, 32'h1234);
        checks++; if (op2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_op2 got=%h expected=ffffffff", op2); end
        checks++; if (funct7 !== 7'd0 || rd !== 5'd1) begin errors++; $display("FAIL addi_f7_rd got=%h/%0d expected=0/1", funct7, rd); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got=%b expected=0", illegal); end
        send(32'h8000F113, 32'd9, 32'd0);
        checks++; if (op2 !== 32'hFFFFF800 || funct7 !== 7'd0) begin errors++; $display("FAIL andi_op2_f7 got=%h/%h expected=fffff800/0", op2, funct7); end
        send(32'h40435293, 32'h80000000, 32'd9);
        checks++; if (op2 !== 32'd4 || funct3 !== 3'd5) begin errors++; $display("FAIL srai_op2_f3 got=%h/%0d expected=4/5", op2, funct3); end
        checks++; if (funct7 !== 7'h20 || rd !== 5'd5) begin errors++; $display("FAIL srai_f7_rd got=%h/%0d expected=20/5", funct7, rd); end
        send(32'h022081B3, 32'd3, 32'd4);
        checks++; if (out_valid !== 1'b1 || funct7 !== 7'h01) begin errors++; $display("FAIL mul_f7 got=%b/%h expected=1/01", out_valid, funct7); end
        drain();
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int k = 0; k < 4; k++) send(32'h00208033 | (32'(k + 1) << 7), 32'(k * 5), 32'(k * 3 + 1));
        drain();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b expected=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int f0 = fired;
        out_ready = 0;
        send(32'h002081B3, 32'd11, 32'd1);
        send(32'h00208233, 32'd22, 32'd2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got=%b expected=0", in_ready); end
        instr = 32'h002082B3; rs1_val = 32'd33; rs2_val = 32'd3; in_valid = 1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b1 || op1 !== 32'd11) begin errors++; $display("FAIL b2b_hold got=%b/%0d expected=1/11", out_valid, op1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got=%b expected=0", in_ready); end
        out_ready = 1;
        send(32'h002082B3, 32'd33, 32'd3);
        drain();
        @(posedge clk); #1;
        checks++; if (fired - f0 !== 3) begin errors++; $display("FAIL b2b_count got=%0d expected=3", fired - f0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b expected=0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] bad_words [3] = '{32'h0000A083, 32'h042081B3, 32'h20431293};
        out_ready = 1;
        foreach (bad_words[k]) begin
            send(bad_words[k], 32'd1, 32'd2);
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse[%0d] got=%b expected=1", k, illegal); end
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL illegal_drop[%0d] got=%b/%b expected=0/1", k, out_valid, in_ready); end
            @(posedge clk); #1;
            checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_width[%0d] got=%b expected=0", k, illegal); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        send(32'h002081B3, 32'd1, 32'd1);
        send(32'h00208233, 32'd2, 32'd2);
        @(posedge clk); #3;
        rst_n = 0;
        q.delete();
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_now got=%b/%b expected=0/1", out_valid, in_ready); end
        checks++; if (op1 !== 32'd0) begin errors++; $display("FAIL arst_op1 got=%h expected=0", op1); end
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_quiet got=%b expected=0", out_valid); end
        end
        send(32'h002082B3, 32'd44, 32'd4);
        checks++; if (out_valid !== 1'b1 || op1 !== 32'd44) begin errors++; $display("FAIL arst_resume got=%b/%0d expected=1/44", out_valid, op1); end
        drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_itype();
        test_stream();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
